// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module : vga_timing_pkg
//  Brief  : Shared VGA timing definitions: per-axis timing record, standard
//           mode presets and the total-period derivation used by the
//           timing generator.
//  Rev    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  // One axis (horizontal in pixels, vertical in lines) of a video mode,
  // listed in scan order: active, front porch, sync, back porch.
  typedef struct packed {
    int active;
    int front;
    int sync;
    int back;
  } vga_axis_t;

  localparam vga_axis_t H_640X480 = '{active: 640, front: 16, sync: 96,  back: 48};
  localparam vga_axis_t V_640X480 = '{active: 480, front: 10, sync: 2,   back: 33};
  localparam vga_axis_t H_800X600 = '{active: 800, front: 40, sync: 128, back: 88};
  localparam vga_axis_t V_800X600 = '{active: 600, front: 1,  sync: 4,   back: 23};

  // Full period of one axis (line length in pixels or frame length in lines).
  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
//  Module : clk_en_div
//  Brief  : Clock-enable divider. Counts 0..CLK_DIV-1 on enabled clocks and
//           emits a one-clk registered tick when the count wraps.
//  Rev    : 1.0  initial release
//
//  Ports
//    clk      in   system clock
//    reset    in   asynchronous active-high reset
//    en       in   count enable; low freezes the count and clears tick
//    tick_pre out  combinational: the current clock edge produces a tick
//    tick     out  registered one-clk tick, valid the cycle after tick_pre
// ============================================================================
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick_pre,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // With CLK_DIV=1 CNT_LAST is 0, so every enabled clock is a tick.
  assign tick_pre = en && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= tick_pre;
      if (en) begin
        cnt <= tick_pre ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module : vga_timing_gen
//  Brief  : VGA raster timing generator. A pixel-rate tick from clk_en_div
//           drives horizontal/vertical position counters; sync, blanking and
//           active-area coordinates are decoded and registered together with
//           the tick so every output describes the same pixel.
//  Rev    : 1.0  initial release
//
//  Ports
//    clk          in   system clock
//    reset        in   asynchronous active-high reset
//    en           in   timing enable; low freezes divider and counters
//    p_tick       out  one-clk pixel-rate pulse
//    hsync        out  horizontal sync, active level HS_POL
//    vsync        out  vertical sync, active level VS_POL
//    video_on     out  current pixel lies in the active area
//    pixel_x      out  active-area column (0 outside the active area)
//    pixel_y      out  active-area row    (0 outside the active area)
//    line_start   out  pulse with p_tick for the first pixel of a line
//    frame_start  out  pulse with p_tick for the first pixel of a frame
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = H_640X480.active,
  parameter int H_FRONT  = H_640X480.front,
  parameter int H_SYNC   = H_640X480.sync,
  parameter int H_BACK   = H_640X480.back,
  parameter int V_ACTIVE = V_640X480.active,
  parameter int V_FRONT  = V_640X480.front,
  parameter int V_SYNC   = V_640X480.sync,
  parameter int V_BACK   = V_640X480.back,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Region bounds are one bit wider than the counters so that a total of
  // exactly 2^CW still has representable (exclusive) end points.
  localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEGIN  = (CW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [CW:0] HS_END    = (CW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEGIN  = (CW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [CW:0] VS_END    = (CW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          tick_pre;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .tick_pre (tick_pre),
    .tick     (p_tick)
  );

  logic [CW:0] h_ext;
  logic [CW:0] v_ext;
  logic        h_wrap;
  logic        in_active;
  logic        in_hsync;
  logic        in_vsync;

  assign h_ext     = {1'b0, h};
  assign v_ext     = {1'b0, v};
  assign h_wrap    = (h == H_LAST);
  assign in_active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign in_hsync  = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
  assign in_vsync  = (v_ext >= VS_BEGIN) && (v_ext < VS_END);

  // (h,v) is the pixel presented on the next tick. On a tick edge the
  // outputs capture the decode of (h,v) and the counters step past it, so
  // outputs change in the same cycle p_tick is high and the first tick after
  // reset presents pixel (0,0) with line_start and frame_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick_pre) begin
      h <= h_wrap ? '0 : h + CW'(1);
      if (h_wrap) begin
        v <= (v == V_LAST) ? '0 : v + CW'(1);
      end
      video_on    <= in_active;
      pixel_x     <= in_active ? h : '0;
      pixel_y     <= in_active ? v : '0;
      hsync       <= in_hsync ? HS_ON : ~HS_ON;
      vsync       <= in_vsync ? VS_ON : ~VS_ON;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module : tb_vga_timing_gen
//  Brief  : Directed self-checking bench for vga_timing_gen. Three instances:
//           default 640x480 timing, a short-line/default-vertical variant for
//           whole-frame vertical checks, and a tiny positive-polarity mode.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d = 1'b1, rst_t = 1'b1, rst_s = 1'b1;
  logic       en_d = 1'b0, en_t = 1'b0, en_s = 1'b0;

  // default instance
  logic       d_p_tick, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
  logic [9:0] d_pixel_x, d_pixel_y;
  // short line, default vertical, CLK_DIV=1
  logic       t_p_tick, t_hsync, t_vsync, t_video_on, t_line_start, t_frame_start;
  logic [9:0] t_pixel_x, t_pixel_y;
  // tiny mode, positive sync polarity
  logic       s_p_tick, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [3:0] s_pixel_x, s_pixel_y;

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_d), .en(en_d), .p_tick(d_p_tick), .hsync(d_hsync),
    .vsync(d_vsync), .video_on(d_video_on), .pixel_x(d_pixel_x), .pixel_y(d_pixel_y),
    .line_start(d_line_start), .frame_start(d_frame_start)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2)
  ) u_vert (
    .clk(clk), .reset(rst_t), .en(en_t), .p_tick(t_p_tick), .hsync(t_hsync),
    .vsync(t_vsync), .video_on(t_video_on), .pixel_x(t_pixel_x), .pixel_y(t_pixel_y),
    .line_start(t_line_start), .frame_start(t_frame_start)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1), .VS_POL(1), .CW(4)
  ) u_small (
    .clk(clk), .reset(rst_s), .en(en_s), .p_tick(s_p_tick), .hsync(s_hsync),
    .vsync(s_vsync), .video_on(s_video_on), .pixel_x(s_pixel_x), .pixel_y(s_pixel_y),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  task automatic set_rst(input int which, input logic val);
    case (which)
      0: rst_d = val;
      1: rst_t = val;
      default: rst_s = val;
    endcase
  endtask

  task automatic pulse_reset(input int which);
    @(negedge clk);
    set_rst(which, 1'b1);
    repeat (2) @(negedge clk);
    set_rst(which, 1'b0);
  endtask

  // Wait (bounded) for p_tick of one instance; returns clks waited.
  task automatic wait_tick(input int which, input int limit, output int clks);
    logic pt;
    logic got;
    clks = 0;
    got  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      clks++;
      case (which)
        0: pt = d_p_tick;
        1: pt = t_p_tick;
        default: pt = s_p_tick;
      endcase
      if (pt) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout dut=%0d waited=%0d clks, required a tick", which, clks);
    end
  endtask

  task automatic test_reset();
    int gap;
    en_d = 1'b1;
    rst_d = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({d_p_tick, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start} !== 6'b011000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=011000", {d_p_tick, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start});
    end
    checks++;
    if ({d_pixel_x, d_pixel_y} !== 20'd0) begin
      failures++;
      $display("FAIL reset_pixel got x=%0d y=%0d exp 0 0", d_pixel_x, d_pixel_y);
    end
    rst_d = 1'b0;
    wait_tick(0, 10, gap);
    checks++;
    if (gap != 4) begin
      failures++;
      $display("FAIL first_tick_gap got=%0d exp=4", gap);
    end
    checks++;
    if ({d_frame_start, d_line_start, d_video_on, d_hsync, d_vsync} !== 5'b11111 || d_pixel_x !== 10'd0) begin
      failures++;
      $display("FAIL first_pixel got fs/ls/vid/hs/vs=%b x=%0d exp 11111 x=0",
               {d_frame_start, d_line_start, d_video_on, d_hsync, d_vsync}, d_pixel_x);
    end
    wait_tick(0, 10, gap);
    checks++;
    if (gap != 4 || d_pixel_x !== 10'd1 || d_line_start !== 1'b0) begin
      failures++;
      $display("FAIL second_tick got gap=%0d x=%0d ls=%b exp gap=4 x=1 ls=0", gap, d_pixel_x, d_line_start);
    end
  endtask

  task automatic test_hline();
    int gap, total, gap_err, hs_cnt, hs_first, hs_last, vid_cnt, px_err;
    int ls_cnt, ls_err, fs_cnt, vs_err, h, exp_x;
    total = 0; gap_err = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    vid_cnt = 0; px_err = 0; ls_cnt = 0; ls_err = 0; fs_cnt = 0; vs_err = 0;
    en_d = 1'b1;
    pulse_reset(0);
    for (int k = 0; k <= 800; k++) begin
      wait_tick(0, 8, gap);
      if (k > 0) total += gap;
      if (gap != 4) gap_err++;
      h = k % 800;
      if (k < 800) begin
        if (!d_hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = h;
          hs_last = h;
        end
        if (d_video_on) vid_cnt++;
      end
      exp_x = (h < 640) ? h : 0;
      if (d_pixel_x !== 10'(exp_x)) px_err++;
      if (d_line_start) begin
        ls_cnt++;
        if (h != 0) ls_err++;
      end
      if (d_frame_start) fs_cnt++;
      if (d_vsync !== 1'b1) vs_err++;
      if (k == 800) begin
        checks++;
        if (d_video_on !== 1'b1 || d_pixel_y !== 10'd1 || d_pixel_x !== 10'd0) begin
          failures++;
          $display("FAIL line2_start got vid=%b x=%0d y=%0d exp vid=1 x=0 y=1", d_video_on, d_pixel_x, d_pixel_y);
        end
      end
    end
    checks++; if (gap_err != 0) begin failures++; $display("FAIL h_tick_spacing got=%0d bad gaps exp=0", gap_err); end
    checks++; if (total != 3200) begin failures++; $display("FAIL line_clks got=%0d exp=3200", total); end
    checks++; if (hs_cnt != 96) begin failures++; $display("FAIL hsync_width got=%0d exp=96", hs_cnt); end
    checks++; if (hs_first != 656 || hs_last != 751) begin failures++; $display("FAIL hsync_span got=%0d..%0d exp=656..751", hs_first, hs_last); end
    checks++; if (vid_cnt != 640) begin failures++; $display("FAIL h_video_count got=%0d exp=640", vid_cnt); end
    checks++; if (px_err != 0) begin failures++; $display("FAIL pixel_x_track got=%0d errors exp=0", px_err); end
    checks++; if (ls_cnt != 2 || ls_err != 0) begin failures++; $display("FAIL line_start got cnt=%0d misplaced=%0d exp 2 0", ls_cnt, ls_err); end
    checks++; if (fs_cnt != 1) begin failures++; $display("FAIL h_frame_start got=%0d exp=1", fs_cnt); end
    checks++; if (vs_err != 0) begin failures++; $display("FAIL vsync_idle got=%0d errors exp=0", vs_err); end
  endtask

  task automatic test_enable();
    int gap, pulse_err, frz_err;
    pulse_err = 0; frz_err = 0;
    en_d = 1'b1;
    pulse_reset(0);
    for (int k = 0; k <= 100; k++) wait_tick(0, 8, gap);
    checks++;
    if (d_pixel_x !== 10'd100) begin failures++; $display("FAIL en_setup got x=%0d exp=100", d_pixel_x); end
    en_d = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d_p_tick || d_line_start || d_frame_start) pulse_err++;
      if (d_pixel_x !== 10'd100 || d_pixel_y !== 10'd0 || d_video_on !== 1'b1 ||
          d_hsync !== 1'b1 || d_vsync !== 1'b1) frz_err++;
    end
    checks++; if (pulse_err != 0) begin failures++; $display("FAIL en_pulses got=%0d exp=0", pulse_err); end
    checks++; if (frz_err != 0) begin failures++; $display("FAIL en_freeze got=%0d errors exp=0", frz_err); end
    en_d = 1'b1;
    wait_tick(0, 10, gap);
    checks++;
    if (gap != 4 || d_pixel_x !== 10'd101) begin
      failures++;
      $display("FAIL en_resume got gap=%0d x=%0d exp gap=4 x=101", gap, d_pixel_x);
    end
  endtask

  task automatic test_vertical();
    int gap, gap_err, fs_cnt, fs_err, vs_cnt, vs_first, vs_last, vid_lines, py_err, h, v, exp_y;
    gap_err = 0; fs_cnt = 0; fs_err = 0; vs_cnt = 0; vs_first = -1; vs_last = -1;
    vid_lines = 0; py_err = 0;
    en_t = 1'b1;
    pulse_reset(1);
    for (int k = 0; k <= 7350; k++) begin
      wait_tick(1, 4, gap);
      if (gap != 1) gap_err++;
      h = k % 14;
      v = (k / 14) % 525;
      if (t_frame_start) begin
        fs_cnt++;
        if (!t_line_start || (k % 7350) != 0) fs_err++;
      end
      if (h == 0 && k < 7350) begin
        if (!t_vsync) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = v;
          vs_last = v;
        end
        if (t_video_on) vid_lines++;
        exp_y = (v < 480) ? v : 0;
        if (t_pixel_y !== 10'(exp_y)) py_err++;
      end
    end
    checks++; if (gap_err != 0) begin failures++; $display("FAIL div1_spacing got=%0d bad gaps exp=0", gap_err); end
    checks++; if (fs_cnt != 2) begin failures++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
    checks++; if (fs_err != 0) begin failures++; $display("FAIL frame_start_pos got=%0d errors exp=0", fs_err); end
    checks++; if (vs_cnt != 2) begin failures++; $display("FAIL vsync_lines got=%0d exp=2", vs_cnt); end
    checks++; if (vs_first != 490 || vs_last != 491) begin failures++; $display("FAIL vsync_span got=%0d..%0d exp=490..491", vs_first, vs_last); end
    checks++; if (vid_lines != 480) begin failures++; $display("FAIL v_video_lines got=%0d exp=480", vid_lines); end
    checks++; if (py_err != 0) begin failures++; $display("FAIL pixel_y_track got=%0d errors exp=0", py_err); end
  endtask

  task automatic test_mid_reset();
    int gap;
    en_t = 1'b1;
    pulse_reset(1);
    for (int k = 0; k <= 300 * 14 + 3; k++) wait_tick(1, 4, gap);
    checks++;
    if (t_pixel_x !== 10'd3 || t_pixel_y !== 10'd300 || t_video_on !== 1'b1) begin
      failures++;
      $display("FAIL midreset_setup got x=%0d y=%0d vid=%b exp 3 300 1", t_pixel_x, t_pixel_y, t_video_on);
    end
    rst_t = 1'b1;
    #1;
    checks++;
    if ({t_p_tick, t_video_on, t_hsync, t_vsync, t_line_start, t_frame_start} !== 6'b001100 ||
        t_pixel_x !== 10'd0 || t_pixel_y !== 10'd0) begin
      failures++;
      $display("FAIL async_reset got tick/vid/hs/vs/ls/fs=%b x=%0d y=%0d exp 001100 0 0",
               {t_p_tick, t_video_on, t_hsync, t_vsync, t_line_start, t_frame_start}, t_pixel_x, t_pixel_y);
    end
    repeat (2) @(negedge clk);
    rst_t = 1'b0;
    wait_tick(1, 4, gap);
    checks++;
    if (gap != 1 || t_frame_start !== 1'b1 || t_pixel_x !== 10'd0 || t_pixel_y !== 10'd0) begin
      failures++;
      $display("FAIL post_reset got gap=%0d fs=%b x=%0d y=%0d exp 1 1 0 0", gap, t_frame_start, t_pixel_x, t_pixel_y);
    end
  endtask

  task automatic test_small();
    int gap, h, v, hs_cnt, hs_first, hs_last, vs_cnt, vs_line, fs_cnt, fs_err;
    int x49, y49, x50, y50;
    hs_cnt = 0; hs_first = -1; hs_last = -1; vs_cnt = 0; vs_line = -1;
    fs_cnt = 0; fs_err = 0; x49 = -1; y49 = -1; x50 = -1; y50 = -1;
    en_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b1;
    #1;
    checks++;
    if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin
      failures++;
      $display("FAIL pos_pol_reset got hs=%b vs=%b exp 0 0", s_hsync, s_vsync);
    end
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    for (int k = 0; k <= 98; k++) begin
      wait_tick(2, 4, gap);
      h = k % 14;
      v = (k / 14) % 7;
      if (k < 14 && s_hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = h;
        hs_last = h;
      end
      if (h == 0 && k < 98 && s_vsync) begin
        vs_cnt++;
        vs_line = v;
      end
      if (s_frame_start) begin
        fs_cnt++;
        if ((k % 98) != 0) fs_err++;
      end
      if (k == 49) begin x49 = int'(s_pixel_x); y49 = int'(s_pixel_y); end
      if (k == 50) begin x50 = int'(s_pixel_x); y50 = int'(s_pixel_y); end
      if (k == 98) begin
        checks++;
        if (s_pixel_x !== 4'd0 || s_pixel_y !== 4'd0 || s_frame_start !== 1'b1 || s_video_on !== 1'b1) begin
          failures++;
          $display("FAIL small_wrap got x=%0d y=%0d fs=%b vid=%b exp 0 0 1 1", s_pixel_x, s_pixel_y, s_frame_start, s_video_on);
        end
      end
    end
    checks++; if (hs_cnt != 2 || hs_first != 10 || hs_last != 11) begin failures++; $display("FAIL small_hsync got cnt=%0d span=%0d..%0d exp 2 10..11", hs_cnt, hs_first, hs_last); end
    checks++; if (vs_cnt != 1 || vs_line != 5) begin failures++; $display("FAIL small_vsync got cnt=%0d line=%0d exp 1 5", vs_cnt, vs_line); end
    checks++; if (fs_cnt != 2 || fs_err != 0) begin failures++; $display("FAIL small_frame got cnt=%0d misplaced=%0d exp 2 0", fs_cnt, fs_err); end
    checks++; if (x49 != 7 || y49 != 3) begin failures++; $display("FAIL small_last_active got x=%0d y=%0d exp 7 3", x49, y49); end
    checks++; if (x50 != 0 || y50 != 0) begin failures++; $display("FAIL small_porch got x=%0d y=%0d exp 0 0", x50, y50); end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_enable();
    test_vertical();
    test_mid_reset();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning clk cycles per pixel tick (1..16).
REQ-002 Parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-003 Parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-005 Parameter H_BACK, default 48, meaning horizontal back porch in pixels.
REQ-006 Parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-007 Parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-008 Parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-009 Parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-010 Parameter HS_POL, default 0, meaning hsync active level (0 = active-low).
REQ-011 Parameter VS_POL, default 0, meaning vsync active level (0 = active-low).
REQ-012 Parameter CW, default 10, meaning counter/coordinate width; H_TOTAL and V_TOTAL SHALL be at most 2^CW.
REQ-013 clk  input  1  system clock; all state on rising edge.
REQ-014 reset  input  1  asynchronous, active-high reset.
REQ-015 en  input  1  timing enable; low freezes divider and counters.
REQ-016 p_tick  output  1  one-clk pixel-rate enable pulse.
REQ-017 hsync  output  1  horizontal sync at HS_POL polarity.
REQ-018 vsync  output  1  vertical sync at VS_POL polarity.
REQ-019 video_on  output  1  high while (h,v) lies in the active area.
REQ-020 pixel_x  output  CW  active-area column; 0 outside the active area.
REQ-021 pixel_y  output  CW  active-area row; 0 outside the active area.
REQ-022 line_start  output  1  one-clk pulse coincident with p_tick when h wraps to 0.
REQ-023 frame_start  output  1  one-clk pulse coincident with p_tick when (h,v) wraps to (0,0).

Function
REQ-024 H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Region order: active, front porch, sync, back porch.
REQ-025 Divider counts 0..CLK_DIV-1 while en=1; p_tick is registered high for exactly one clk each time the count is CLK_DIV-1. CLK_DIV=1 gives p_tick high on every enabled clk.
REQ-026 On each p_tick, h advances; h at H_TOTAL-1 wraps to 0 and v advances; v at V_TOTAL-1 with h wrap wraps v to 0 on the same tick.
REQ-027 hsync is active for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]; vsync is active for v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1].
REQ-028 hsync, vsync, video_on, pixel_x, pixel_y, line_start and frame_start are registered from the same counter state, so all are mutually cycle-aligned with one clk latency after a counter update.
REQ-029 en=0: divider and counters hold, p_tick/line_start/frame_start are 0, and the other outputs hold. Resumption continues from the held count without skipping.
REQ-030 Counter arithmetic is unsigned CW-bit; no value at or beyond H_TOTAL or V_TOTAL is reachable.

Reset
REQ-031 While reset=1, asynchronously: divider=0, h=0, v=0, p_tick=0, line_start=0, frame_start=0, video_on=0, pixel_x=0, pixel_y=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-032 Reset asserted mid-frame forces the REQ-031 values immediately; after release, the first p_tick occurs on the CLK_DIV-th enabled clk.

Structure
REQ-033 Package vga_timing_pkg holds preset constants (640x480@60, 800x600@60) and the H_TOTAL/V_TOTAL derivation.
REQ-034 The pixel-tick divider is the sub-module clk_en_div (CLK_DIV parameter, en input, tick output); the h/v counters and decode sit in vga_timing_gen.

Verification
REQ-035 Defaults; release reset with en=1 -> p_tick first high on the 4th clk, then every 4 clks; hsync/vsync high (inactive).
REQ-036 Defaults -> hsync low for h 656..751 (96 ticks); line = 800 ticks = 3200 clk; video_on high for h 0..639 and v 0..479 only.
REQ-037 Defaults -> vsync low for lines 490..491; frame = 525 lines; exactly one frame_start per frame, at (0,0), coincident with line_start.
REQ-038 Drop en at h=100 for 50 clk -> p_tick 0, all outputs frozen; on resumption the next tick gives h=101.
REQ-039 Assert reset mid-frame (v=300) -> REQ-031 values appear without waiting for a clk edge; after release the sequence matches REQ-035.
REQ-040 CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1 -> hsync high at h 10..11, vsync high at v 5, frame of 14x7 ticks, and pixel_x/pixel_y wrap to 0 together.
